// File: rtl/mem_unit_param_if.sv
// rtl/mem_unit_param_if.sv - req/ack memory bus between a requester and mem_unit_param
interface mem_unit_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;
  logic                  busy;
  logic                  err;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, rdata, busy, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, rdata, busy, err
  );
endinterface

// File: rtl/mem_unit_param.sv
// rtl/mem_unit_param.sv - word RAM behind a 4-phase req/ack handshake with latency and byte enables
// Optional bounds checking of the word index is enabled by defining MEM_UNIT_BOUNDS_CHECK_EN.
module mem_unit_param #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_unit_param_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [3:0] LAST_CNT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_ACK} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [NB-1:0]       be_q, be_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                oob_q, oob_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic                addr_oob;
  logic                unused_addr;

`ifdef MEM_UNIT_BOUNDS_CHECK_EN
  assign addr_oob = |bus.addr[ADDR_W-1:OFF+IW];
`else
  assign addr_oob = 1'b0;
`endif
  // Byte-offset bits (and upper bits when wrapping) are intentionally dropped.
  assign unused_addr = ^bus.addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    oob_d   = oob_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          be_d    = bus.be;
          idx_d   = bus.addr[OFF +: IW];
          wdata_d = bus.wdata;
          oob_d   = addr_oob;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = (LATENCY > 0) ? S_WAIT : S_COMMIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) state_d = S_COMMIT;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      S_COMMIT: begin
        ack_d   = 1'b1;
        err_d   = oob_q;
        state_d = S_ACK;
        if (we_q) mem_we  = ~oob_q;
        else      rdata_d = oob_q ? '0 : mem[idx_q];
      end
      S_ACK: begin
        // A req already low here yields a one-cycle ack pulse.
        if (!bus.req) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      oob_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      oob_q   <= oob_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset on the commit edge wins, so the write is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_unit_param.sv
// tb/tb_mem_unit_param.sv - self-checking bench for mem_unit_param (LATENCY=2 and LATENCY=0 instances)
module tb_mem_unit_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cur = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_unit_param_if #(.DATA_W(32), .ADDR_W(32)) b2 ();
  mem_unit_param_if #(.DATA_W(32), .ADDR_W(32)) b0 ();

  mem_unit_param #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .bus(b2)
  );
  mem_unit_param #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  logic        ack_s, busy_s, err_s;
  logic [31:0] rdata_s;
  assign ack_s   = cur ? b0.ack   : b2.ack;
  assign busy_s  = cur ? b0.busy  : b2.busy;
  assign err_s   = cur ? b0.err   : b2.err;
  assign rdata_s = cur ? b0.rdata : b2.rdata;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] sb[$];
  logic [31:0] model0 [int];

`ifdef MEM_UNIT_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_fields(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    if (cur) begin b0.we = w; b0.be = b; b0.addr = a; b0.wdata = d; end
    else     begin b2.we = w; b2.be = b; b2.addr = a; b2.wdata = d; end
  endtask

  task automatic set_req(input logic r);
    if (cur) b0.req = r;
    else     b2.req = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    int          cyc;
    bit          seen;
    logic [31:0] hold;
    set_fields(w, b, a, d);
    set_req(1'b1);
    cyc  = 0;
    seen = 0;
    while (cyc < 40 && !seen) begin
      tick();
      cyc++;
      if (ack_s) seen = 1;
      else if (cyc == 1) chk("busy_after_capture", 32'(busy_s), 32'd1);
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("ack_latency", 32'(cyc - 1), cur ? 32'd1 : 32'd3);
    rd   = rdata_s;
    er   = err_s;
    hold = rdata_s;
    tick();
    chk("ack_held", 32'(ack_s), 32'd1);
    chk("rdata_stable", rdata_s, hold);
    set_req(1'b0);
    tick();
    chk("ack_drop", 32'(ack_s), 32'd0);
    chk("busy_drop", 32'(busy_s), 32'd0);
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    sb.push_back(exp);
    txn(1'b0, 4'h0, a, 32'h0, rd, er);
    chk(name, rd, sb.pop_front());
    chk({name, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic do_write(input string name, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err);
    logic [31:0] rd;
    logic        er;
    txn(1'b1, b, a, d, rd, er);
    chk({name, "_err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    int first_ack;
    int ack_cnt;
    int busy_cnt;

    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'hF, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{1'b1, 4'h5, 32'h0000_0004, 32'h1122_3344, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0000_0004, 32'h0,         32'hDE22_BE44};
    vecs[5]  = '{1'b1, 4'hF, 32'h0000_0008, 32'h1234_5678, 32'h0};
    vecs[6]  = '{1'b1, 4'h0, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{1'b0, 4'h0, 32'h0000_0008, 32'h0,         32'h1234_5678};
    vecs[8]  = '{1'b0, 4'h0, 32'h0000_0003, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 4'hA, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D};

    b2.req = 1'b0; b2.we = 1'b0; b2.be = '0; b2.addr = '0; b2.wdata = '0;
    b0.req = 1'b0; b0.we = 1'b0; b0.be = '0; b0.addr = '0; b0.wdata = '0;

    rst = 1'b1;
    repeat (10) tick();
    rst = 1'b0;
    chk("rst_ack",   32'(b2.ack),  32'd0);
    chk("rst_busy",  32'(b2.busy), 32'd0);
    chk("rst_err",   32'(b2.err),  32'd0);
    chk("rst_rdata", b2.rdata,     32'd0);
    chk("rst_ack0",  32'(b0.ack),  32'd0);

    cur = 1'b0;
    // be=4'hA on 0xFFC writes only bytes 1 and 3, so preload full word first.
    do_write("pre_ffc", 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) do_write($sformatf("vec%0d_w", i), vecs[i].be, vecs[i].addr, vecs[i].wdata, 1'b0);
      else            do_read($sformatf("vec%0d_r", i), vecs[i].addr, vecs[i].exp, 1'b0);
    end

    // req held 10 cycles while we/addr/wdata change; only the captured write happens
    set_fields(1'b1, 4'hF, 32'h0000_0010, 32'h0BAD_F00D);
    set_req(1'b1);
    first_ack = 0; ack_cnt = 0; busy_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      set_fields(i[0], 4'hF, (i[0] ? 32'h0 : 32'h40), 32'hFFFF_FFFF);
      if (ack_s) begin
        ack_cnt++;
        if (first_ack == 0) first_ack = i;
      end
      if (busy_s) busy_cnt++;
    end
    chk("hold_first_ack", 32'(first_ack), 32'd4);
    chk("hold_ack_cnt",   32'(ack_cnt),   32'd7);
    chk("hold_busy_cnt",  32'(busy_cnt),  32'd10);
    set_req(1'b0);
    tick();
    chk("hold_ack_drop", 32'(ack_s), 32'd0);
    do_read("hold_rd10", 32'h0000_0010, 32'h0BAD_F00D, 1'b0);
    do_read("hold_rd0",  32'h0000_0000, 32'hDEAD_BEEF, 1'b0);

    // Wrap / bounds check at word index 1024
    do_write("wrap_w", 4'hF, 32'h0000_1000, 32'hA5A5_A5A5, BCHK);
    do_read("wrap_rd0", 32'h0000_0000, BCHK ? 32'hDEAD_BEEF : 32'hA5A5_A5A5, 1'b0);
    do_read("wrap_rd1000", 32'h0000_1000, BCHK ? 32'h0 : 32'hA5A5_A5A5, BCHK);

    // req dropped right after capture: single ack pulse, write still lands
    set_fields(1'b1, 4'hF, 32'h0000_0030, 32'h5A5A_0000);
    set_req(1'b1);
    tick();
    set_req(1'b0);
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack_s) ack_cnt++;
    end
    chk("drop_ack_pulse", 32'(ack_cnt), 32'd1);
    chk("drop_busy_end",  32'(busy_s),  32'd0);
    do_read("drop_rd", 32'h0000_0030, 32'h5A5A_0000, 1'b0);

    // Reset one cycle before the commit edge aborts the write
    do_write("rst_pre_w", 4'hF, 32'h0000_0020, 32'h1111_1111, 1'b0);
    do_read("rst_pre_r", 32'h0000_0020, 32'h1111_1111, 1'b0);
    set_fields(1'b1, 4'hF, 32'h0000_0020, 32'h2222_2222);
    set_req(1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0);
    chk("abort_ack",   32'(ack_s),  32'd0);
    chk("abort_busy",  32'(busy_s), 32'd0);
    chk("abort_err",   32'(err_s),  32'd0);
    chk("abort_rdata", rdata_s,     32'd0);
    ack_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_s) ack_cnt++;
    end
    chk("abort_no_ack", 32'(ack_cnt), 32'd0);
    do_read("abort_rd", 32'h0000_0020, 32'h1111_1111, 1'b0);

    // LATENCY=0 instance: random write/read pairs against the scoreboard model
    cur = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'($urandom_range(0, 1023)) << 2;
      d = $urandom;
      do_write($sformatf("l0_w%0d", i), 4'hF, a, d, 1'b0);
      model0[int'(a >> 2)] = d;
      do_read($sformatf("l0_r%0d", i), a, model0[int'(a >> 2)], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
